// File: rtl/bram_row_packer.sv
// Packs a frame of 8-bit pixels little-endian into 64-bit words and streams
// them sequentially into BRAM port A; the last partial word is zero-padded.

module bram_pack_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       clr,
  input  logic [7:0] din,
  output logic [7:0] merged
);
  logic [7:0] q;

  // A committing byte bypasses the register so the word is complete on the same edge.
  assign merged = sel ? din : q;

  always_ff @(posedge clk) begin
    if (reset || clr) q <= '0;
    else if (sel)     q <= din;
  end
endmodule

module bram_row_packer #(
  parameter int FRAME_BYTES = 200,
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [63:0]       dina,
  output logic              busy,
  output logic              done
);
  localparam int NUM_LANES = 8;
  localparam int CNT_RAW   = $clog2(FRAME_BYTES);
  localparam int CNT_W     = (CNT_RAW < 3) ? 3 : CNT_RAW;

  typedef enum logic [1:0] {IDLE, PACK, LAST} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q;
  logic [2:0]                      lane;
  logic                            fire, last_byte, commit;
  logic [NUM_LANES-1:0][7:0]       merged;
  logic [ADDR_W-1:0]               word_addr;

  assign lane      = cnt_q[2:0];
  assign fire      = (state_q == PACK) && in_valid;
  assign last_byte = (cnt_q == CNT_W'(FRAME_BYTES - 1));
  assign commit    = fire && ((lane == 3'd7) || last_byte);
  assign word_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q >> 3);
  assign wea       = ena;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    bram_pack_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .sel    (fire && (lane == 3'(l))),
      .clr    (commit),
      .din    (in_data),
      .merged (merged[l])
    );
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = PACK;
      end
      PACK: begin
        in_ready = 1'b1;
        if (fire && last_byte) state_d = LAST;
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ena     <= 1'b0;
      done    <= 1'b0;
      addra   <= ADDR_W'(BASE_ADDR);
      dina    <= '0;
    end else begin
      state_q <= state_d;
      ena     <= commit;
      done    <= fire && last_byte;
      if (commit) begin
        addra <= word_addr;
        dina  <= merged;
      end
      if (state_q != PACK)  cnt_q <= '0;
      else if (fire)        cnt_q <= last_byte ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_bram_row_packer.sv
// Directed bench for bram_row_packer: three parameterisations checked every
// cycle against a frame-level byte/word model plus literal word expectations.

module tb_bram_row_packer;
  localparam int NI = 3;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst [NI];
  logic          start [NI];
  logic          in_valid [NI];
  logic [7:0]    in_data [NI];
  logic          in_ready [NI];
  logic          ena [NI];
  logic          wea [NI];
  logic          busy [NI];
  logic          done [NI];
  logic [AW-1:0] addra [NI];
  logic [63:0]   dina [NI];

  int fbv [NI] = '{200, 13, 32};
  int bav [NI] = '{0, 0, 254};

  bram_row_packer #(.FRAME_BYTES(200), .ADDR_W(AW), .BASE_ADDR(0)) u0 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ena(ena[0]), .wea(wea[0]), .addra(addra[0]), .dina(dina[0]),
    .busy(busy[0]), .done(done[0]));
  bram_row_packer #(.FRAME_BYTES(13), .ADDR_W(AW), .BASE_ADDR(0)) u1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ena(ena[1]), .wea(wea[1]), .addra(addra[1]), .dina(dina[1]),
    .busy(busy[1]), .done(done[1]));
  bram_row_packer #(.FRAME_BYTES(32), .ADDR_W(AW), .BASE_ADDR(254)) u2 (
    .clk(clk), .reset(rst[2]), .start(start[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .ena(ena[2]), .wea(wea[2]), .addra(addra[2]), .dina(dina[2]),
    .busy(busy[2]), .done(done[2]));

  int vec = 0;
  int mis = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    vec++;
    if (got !== want) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Model: frame active / in final cycle / bytes taken so far, and expected outputs.
  int            m_act [NI];
  int            m_lst [NI];
  int            m_n [NI];
  logic [7:0]    m_b [NI][256];
  logic          e_ena [NI];
  logic          e_done [NI];
  logic [AW-1:0] e_addr [NI];
  logic [63:0]   e_dina [NI];

  // Shadow BRAM and event bookkeeping
  logic [63:0]   mem [NI][256];
  logic [63:0]   ref0 [256];
  int            wr_cnt [NI];
  int            done_cnt [NI];
  int            done_cyc [NI];
  int            first_busy [NI];
  logic          prev_busy [NI];
  int            wq [$];
  int            cyc = 0;

  initial begin : cmp
    int n, base;
    logic [63:0] w;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("ena%0d", i),   64'(ena[i]),   64'(e_ena[i]));
        chk($sformatf("wea%0d", i),   64'(wea[i]),   64'(e_ena[i]));
        chk($sformatf("done%0d", i),  64'(done[i]),  64'(e_done[i]));
        chk($sformatf("busy%0d", i),  64'(busy[i]),  64'(m_act[i] != 0));
        chk($sformatf("rdy%0d", i),   64'(in_ready[i]), 64'(m_act[i] != 0 && m_lst[i] == 0));
        chk($sformatf("addra%0d", i), 64'(addra[i]), 64'(e_addr[i]));
        chk($sformatf("dina%0d", i),  dina[i],       e_dina[i]);

        if (ena[i] === 1'b1) begin
          mem[i][addra[i]] = dina[i];
          wr_cnt[i]++;
          if (i == 2) wq.push_back(int'(addra[i]));
        end
        if (done[i] === 1'b1) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        if (busy[i] === 1'b1 && prev_busy[i] !== 1'b1) first_busy[i] = cyc;
        prev_busy[i] = busy[i];

        // Advance the model with the inputs the next rising edge will sample.
        e_ena[i]  = 1'b0;
        e_done[i] = 1'b0;
        if (rst[i]) begin
          m_act[i] = 0; m_lst[i] = 0; m_n[i] = 0;
          e_addr[i] = AW'(bav[i]);
          e_dina[i] = '0;
        end else if (m_lst[i] != 0) begin
          m_act[i] = 0; m_lst[i] = 0;
        end else if (m_act[i] == 0) begin
          if (start[i]) begin m_act[i] = 1; m_n[i] = 0; end
        end else if (in_valid[i]) begin
          n = m_n[i];
          m_b[i][n] = in_data[i];
          if (n % 8 == 7 || n == fbv[i] - 1) begin
            base = n - n % 8;
            w = '0;
            for (int j = base; j <= n; j++) w |= 64'(m_b[i][j]) << (8 * (j - base));
            e_ena[i]  = 1'b1;
            e_addr[i] = AW'((bav[i] + n / 8) % (1 << AW));
            e_dina[i] = w;
          end
          if (n == fbv[i] - 1) begin e_done[i] = 1'b1; m_lst[i] = 1; end
          m_n[i] = n + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log(input int i);
    wr_cnt[i] = 0;
    done_cnt[i] = 0;
    for (int a = 0; a < 256; a++) mem[i][a] = '0;
  endtask

  // One frame of bytes k mod 256; optional random bubbles and stray start pulses.
  task automatic run_frame(input int i, input bit bub, input bit pulse);
    int k;
    bit v;
    k = 0;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    while (k < fbv[i]) begin
      v = bub ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_valid[i] = v;
      in_data[i]  = 8'(k);
      start[i]    = pulse && (k == 3 || k == 100);
      tick();
      if (v) k++;
    end
    in_valid[i] = 1'b0;
    start[i]    = pulse;
    tick();
    start[i]    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0;
      m_act[i] = 0; m_lst[i] = 0; m_n[i] = 0;
      e_ena[i] = 1'b0; e_done[i] = 1'b0; e_addr[i] = AW'(bav[i]); e_dina[i] = '0;
      first_busy[i] = 0; done_cyc[i] = 0; prev_busy[i] = 1'b0;
      clear_log(i);
    end
    repeat (3) tick();
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    repeat (2) tick();
    chk("idle_ready", 64'(in_ready[0]), 64'(0));
    chk("idle_addra_base", 64'(addra[2]), 64'(254));

    // Continuous 200-byte frame
    run_frame(0, 1'b0, 1'b0);
    chk("full_writes", 64'(wr_cnt[0]), 64'(25));
    chk("full_dones", 64'(done_cnt[0]), 64'(1));
    chk("full_latency", 64'(done_cyc[0] - first_busy[0]), 64'(200));
    chk("full_word0", mem[0][0], 64'h0706050403020100);
    chk("full_word24", mem[0][24], 64'hC7C6C5C4C3C2C1C0);
    for (int a = 0; a < 256; a++) ref0[a] = mem[0][a];
    clear_log(0);

    // Back-to-back start, bubbles and ignored start pulses
    run_frame(0, 1'b1, 1'b1);
    chk("bub_writes", 64'(wr_cnt[0]), 64'(25));
    chk("bub_dones", 64'(done_cnt[0]), 64'(1));
    for (int a = 0; a < 25; a++) chk($sformatf("bub_word%0d", a), mem[0][a], ref0[a]);

    // Partial final word
    run_frame(1, 1'b0, 1'b0);
    tick();
    chk("part_writes", 64'(wr_cnt[1]), 64'(2));
    chk("part_dones", 64'(done_cnt[1]), 64'(1));
    chk("part_word0", mem[1][0], 64'h0706050403020100);
    chk("part_word1", mem[1][1], 64'h0000000C0B0A0908);

    // Address wrap
    run_frame(2, 1'b1, 1'b0);
    chk("wrap_count", 64'(wq.size()), 64'(4));
    if (wq.size() == 4) begin
      chk("wrap_a0", 64'(wq[0]), 64'(254));
      chk("wrap_a1", 64'(wq[1]), 64'(255));
      chk("wrap_a2", 64'(wq[2]), 64'(0));
      chk("wrap_a3", 64'(wq[3]), 64'(1));
    end
    chk("wrap_word255", mem[2][255], 64'h0F0E0D0C0B0A0908);

    // Reset after 11 bytes, with start held during reset
    clear_log(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k < 11; k++) begin
      in_valid[0] = 1'b1; in_data[0] = 8'(k);
      tick();
    end
    in_data[0] = 8'd11;
    rst[0] = 1'b1; start[0] = 1'b1;
    tick();
    rst[0] = 1'b0; start[0] = 1'b0; in_valid[0] = 1'b0;
    repeat (3) tick();
    chk("rst_writes", 64'(wr_cnt[0]), 64'(1));
    chk("rst_dones", 64'(done_cnt[0]), 64'(0));
    chk("rst_no_word1", mem[0][1], 64'h0);
    chk("rst_ready", 64'(in_ready[0]), 64'(0));

    clear_log(0);
    run_frame(0, 1'b0, 1'b0);
    chk("post_writes", 64'(wr_cnt[0]), 64'(25));
    chk("post_word0", mem[0][0], 64'h0706050403020100);
    chk("post_word1", mem[0][1], 64'h0F0E0D0C0B0A0908);
    chk("post_word24", mem[0][24], 64'hC7C6C5C4C3C2C1C0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
